// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle.
// Results outside the DIGITS-digit range saturate to all nines and set overflow.
module bin2bcd_seq #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [IN_WIDTH-1:0]   bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  // Largest displayable value, kept in 64 bits so DIGITS=10 does not wrap.
  localparam logic [63:0] MAX_VAL = (64'd10 ** DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                        state, state_next;
  logic [IN_WIDTH-1:0]           shreg;
  logic [BW-1:0]                 acc;
  logic [BW-1:0]                 acc_adj;
  logic [BW+IN_WIDTH-1:0]        shifted;
  logic [CW-1:0]                 cnt;
  logic                          accept;
  logic                          too_big;

  assign in_ready = (state == IDLE) && !reset;
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;
  assign too_big  = 64'(bin_in) > MAX_VAL;

  // Add 3 to every digit that would reach 10 or more after doubling.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
    shifted = {acc_adj, shreg} << 1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = too_big ? DONE : SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= bin_in;
            acc   <= '0;
            cnt   <= CW'(IN_WIDTH);
            if (too_big) begin
              bcd_out  <= {DIGITS{4'h9}};
              overflow <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc   <= shifted[BW+IN_WIDTH-1:IN_WIDTH];
          shreg <= shifted[IN_WIDTH-1:0];
          cnt   <= cnt - 1'b1;
          // The last shift goes straight to the output so the display never sees partial values.
          if (cnt == CW'(1)) begin
            bcd_out  <= shifted[BW+IN_WIDTH-1:IN_WIDTH];
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: default instance (32/3) and a 16-bit/5-digit instance,
// compared against an arithmetic divide-by-ten reference model.
module tb_bin2bcd_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bin_in;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] bcd_out;
  logic        overflow;
  logic        done;

  logic [15:0] bin_in2;
  logic        in_valid2;
  logic        in_ready2;
  logic [19:0] bcd_out2;
  logic        overflow2;
  logic        done2;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  bin2bcd_seq #(.IN_WIDTH(32), .DIGITS(3)) dut (
    .clock(clock), .reset(reset), .bin_in(bin_in), .in_valid(in_valid),
    .in_ready(in_ready), .bcd_out(bcd_out), .overflow(overflow), .done(done)
  );

  bin2bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) dut2 (
    .clock(clock), .reset(reset), .bin_in(bin_in2), .in_valid(in_valid2),
    .in_ready(in_ready2), .bcd_out(bcd_out2), .overflow(overflow2), .done(done2)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: saturate above 10^digits-1, otherwise peel decimal digits with % and /.
  function automatic logic [39:0] model_bcd(input logic [63:0] v, input int digits,
                                            output logic ovf);
    logic [63:0] lim;
    logic [63:0] x;
    logic [39:0] r;
    lim = 64'd1;
    for (int i = 0; i < digits; i++) lim = lim * 64'd10;
    lim = lim - 64'd1;
    r = '0;
    x = v;
    if (x > lim) begin
      ovf = 1'b1;
      for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
    end else begin
      ovf = 1'b0;
      for (int i = 0; i < digits; i++) begin
        r[4*i +: 4] = 4'(x % 64'd10);
        x = x / 64'd10;
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one accept on the chosen instance and observes the result; cycle 0 is the accept cycle.
  task automatic do_conv(input bit sel, input logic [31:0] v, output int lat,
                         output logic [19:0] bcd, output logic ovf,
                         output bit ready_ok, output bit held_ok);
    logic [19:0] prev;
    int waitc;
    waitc = 0;
    ready_ok = 1'b1;
    held_ok = 1'b1;
    lat = -1;
    bcd = '0;
    ovf = 1'b0;
    while (!(sel ? in_ready2 : in_ready) && waitc < 50) begin
      step();
      waitc++;
    end
    if (sel) begin
      bin_in2 = v[15:0];
      in_valid2 = 1'b1;
    end else begin
      bin_in = v;
      in_valid = 1'b1;
    end
    prev = sel ? bcd_out2 : {8'h00, bcd_out};
    step();
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    bin_in = $urandom;
    bin_in2 = 16'($urandom);
    for (int c = 1; c <= 40; c++) begin
      if (sel ? done2 : done) begin
        lat = c;
        bcd = sel ? bcd_out2 : {8'h00, bcd_out};
        ovf = sel ? overflow2 : overflow;
        if (sel ? in_ready2 : in_ready) ready_ok = 1'b0;
        step();
        if (!(sel ? in_ready2 : in_ready)) ready_ok = 1'b0;
        break;
      end
      if (sel ? in_ready2 : in_ready) ready_ok = 1'b0;
      if ((sel ? bcd_out2 : {8'h00, bcd_out}) !== prev) held_ok = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_valid2 = 1'b0;
    bin_in = '0;
    bin_in2 = '0;
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0", in_ready); end
    checks++; if (bcd_out !== 12'h000) begin fails++; $display("[TB] FAIL reset_bcd: got %h expected 000", bcd_out); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (in_ready2 !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready2: got %b expected 0", in_ready2); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] vals[6] = '{32'd0, 32'd255, 32'd999, 32'd1000, 32'hFFFFFFFF, 32'd7};
    logic [11:0] expb[6] = '{12'h000, 12'h255, 12'h999, 12'h999, 12'h999, 12'h007};
    logic        expo[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int          expl[6] = '{33, 33, 33, 1, 1, 33};
    int lat;
    logic [19:0] bcd;
    logic ovf;
    bit rok, hok;
    for (int i = 0; i < 6; i++) begin
      do_conv(1'b0, vals[i], lat, bcd, ovf, rok, hok);
      checks++; if (lat !== expl[i]) begin fails++; $display("[TB] FAIL dir_latency(%0d): got %0d expected %0d", vals[i], lat, expl[i]); end
      checks++; if (bcd[11:0] !== expb[i]) begin fails++; $display("[TB] FAIL dir_bcd(%0d): got %h expected %h", vals[i], bcd[11:0], expb[i]); end
      checks++; if (ovf !== expo[i]) begin fails++; $display("[TB] FAIL dir_ovf(%0d): got %b expected %b", vals[i], ovf, expo[i]); end
      checks++; if (rok !== 1'b1) begin fails++; $display("[TB] FAIL dir_ready_window(%0d): got %b expected 1", vals[i], rok); end
      checks++; if (hok !== 1'b1) begin fails++; $display("[TB] FAIL dir_bcd_held(%0d): got %b expected 1", vals[i], hok); end
    end
  endtask

  task automatic test_busy_ignore();
    int dones, done_cyc, lat2;
    logic [11:0] bcd_seen;
    bin_in = 32'd123;
    in_valid = 1'b1;
    step();
    dones = 0;
    done_cyc = -1;
    bcd_seen = '0;
    for (int c = 1; c <= 33; c++) begin
      in_valid = (c == 5 || c == 33);
      bin_in = in_valid ? 32'd456 : $urandom;
      if (done) begin
        dones++;
        done_cyc = c;
        bcd_seen = bcd_out;
      end
      step();
    end
    in_valid = 1'b1;
    bin_in = 32'd456;
    checks++; if (dones !== 1) begin fails++; $display("[TB] FAIL busy_done_count: got %0d expected 1", dones); end
    checks++; if (done_cyc !== 33) begin fails++; $display("[TB] FAIL busy_done_cycle: got %0d expected 33", done_cyc); end
    checks++; if (bcd_seen !== 12'h123) begin fails++; $display("[TB] FAIL busy_bcd: got %h expected 123", bcd_seen); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL busy_ready34: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    lat2 = -1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat2 = c;
        bcd_seen = bcd_out;
        break;
      end
      step();
    end
    checks++; if (lat2 !== 33) begin fails++; $display("[TB] FAIL busy_second_latency: got %0d expected 33", lat2); end
    checks++; if (bcd_seen !== 12'h456) begin fails++; $display("[TB] FAIL busy_second_bcd: got %h expected 456", bcd_seen); end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, dones;
    logic [19:0] bcd;
    logic ovf;
    bit rok, hok;
    do_conv(1'b0, 32'd42, lat, bcd, ovf, rok, hok);
    checks++; if (bcd[11:0] !== 12'h042) begin fails++; $display("[TB] FAIL mid_first_bcd: got %h expected 042", bcd[11:0]); end
    bin_in = 32'd87;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    dones = 0;
    for (int c = 1; c <= 9; c++) begin
      if (done) dones++;
      step();
    end
    reset = 1'b1;
    if (done) dones++;
    step();
    reset = 1'b0;
    #1;
    checks++; if (bcd_out !== 12'h000) begin fails++; $display("[TB] FAIL mid_bcd_cleared: got %h expected 000", bcd_out); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL mid_ovf_cleared: got %b expected 0", overflow); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL mid_ready_after: got %b expected 1", in_ready); end
    for (int c = 0; c < 40; c++) begin
      if (done) dones++;
      step();
    end
    checks++; if (dones !== 0) begin fails++; $display("[TB] FAIL mid_no_done: got %0d expected 0", dones); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[4] = '{32'd5, 32'd2000, 32'd314, 32'd0};
    int exp_cyc[4];
    int idx, didx, cyc, waitc, t;
    logic ovf_m;
    logic [39:0] mb;
    // With in_valid held, each accept lands on the cycle after the previous done.
    t = -1;
    for (int i = 0; i < 4; i++) begin
      mb = model_bcd({32'd0, q[i]}, 3, ovf_m);
      t = t + 1 + (ovf_m ? 1 : 33);
      exp_cyc[i] = t;
    end
    waitc = 0;
    while (!in_ready && waitc < 50) begin step(); waitc++; end
    idx = 0;
    didx = 0;
    cyc = 0;
    in_valid = 1'b1;
    while (didx < 4 && cyc < 300) begin
      if (in_ready) begin
        if (idx < 4) begin
          bin_in = q[idx];
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (done) begin
        mb = model_bcd({32'd0, q[didx]}, 3, ovf_m);
        checks++; if (cyc !== exp_cyc[didx]) begin fails++; $display("[TB] FAIL b2b_cycle(%0d): got %0d expected %0d", didx, cyc, exp_cyc[didx]); end
        checks++; if (bcd_out !== mb[11:0]) begin fails++; $display("[TB] FAIL b2b_bcd(%0d): got %h expected %h", didx, bcd_out, mb[11:0]); end
        checks++; if (overflow !== ovf_m) begin fails++; $display("[TB] FAIL b2b_ovf(%0d): got %b expected %b", didx, overflow, ovf_m); end
        didx++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (didx !== 4) begin fails++; $display("[TB] FAIL b2b_completions: got %0d expected 4", didx); end
    step();
  endtask

  task automatic test_param_sweep();
    int lat;
    logic [19:0] bcd;
    logic ovf, ovf_m;
    logic [39:0] mb;
    logic [15:0] v;
    bit rok, hok;
    for (int i = 0; i < 22; i++) begin
      v = (i == 0) ? 16'd65535 : (i == 1) ? 16'd9 : 16'($urandom);
      mb = model_bcd({48'd0, v}, 5, ovf_m);
      do_conv(1'b1, {16'd0, v}, lat, bcd, ovf, rok, hok);
      checks++; if (lat !== 17) begin fails++; $display("[TB] FAIL p16_latency(%0d): got %0d expected 17", v, lat); end
      checks++; if (bcd !== mb[19:0]) begin fails++; $display("[TB] FAIL p16_bcd(%0d): got %h expected %h", v, bcd, mb[19:0]); end
      checks++; if (ovf !== 1'b0) begin fails++; $display("[TB] FAIL p16_ovf(%0d): got %b expected 0", v, ovf); end
      checks++; if (rok !== 1'b1) begin fails++; $display("[TB] FAIL p16_ready_window(%0d): got %b expected 1", v, rok); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [19:0] bcd;
    logic ovf, ovf_m;
    logic [39:0] mb;
    logic [31:0] v;
    bit rok, hok;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom_range(990, 1010);
        default: v = $urandom_range(0, 999);
      endcase
      mb = model_bcd({32'd0, v}, 3, ovf_m);
      do_conv(1'b0, v, lat, bcd, ovf, rok, hok);
      checks++; if (lat !== (ovf_m ? 1 : 33)) begin fails++; $display("[TB] FAIL rnd_latency(%0d): got %0d expected %0d", v, lat, ovf_m ? 1 : 33); end
      checks++; if (bcd[11:0] !== mb[11:0]) begin fails++; $display("[TB] FAIL rnd_bcd(%0d): got %h expected %h", v, bcd[11:0], mb[11:0]); end
      checks++; if (ovf !== ovf_m) begin fails++; $display("[TB] FAIL rnd_ovf(%0d): got %b expected %b", v, ovf, ovf_m); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_param_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-add-3 (double-dabble).
- Sits directly upstream of the three-digit seven-segment display top. It takes a 32-bit binary result from the core, such as a Fibonacci value, and produces packed BCD digits.
- Digit k occupies bits [4k+3:4k], so digit 0 is the least significant. The display consumes bits [11:0] directly.
- Values above the displayable range saturate to all nines and raise an overflow flag.

Parameters:
- IN_WIDTH, default 32: width of the binary input. Legal range 1..32.
- DIGITS, default 3: number of BCD output digits. Legal range 1..10.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- bin_in  input  IN_WIDTH  unsigned binary value to convert
- in_valid  input  1  bin_in is valid this cycle
- in_ready  output  1  converter is idle and accepts a new value
- bcd_out  output  4*DIGITS  packed BCD result, registered, held until the next completion
- overflow  output  1  last result saturated, registered, held with bcd_out
- done  output  1  one-cycle pulse: bcd_out and overflow were updated this cycle

Behaviour:
- One clock domain. Reset is synchronous and active-high, with ports named clock and reset.
- Reset values:
  - State is IDLE.
  - bcd_out, overflow, done and all internal registers are 0.
  - in_ready is 0 in any cycle where reset is high, and 1 in the first cycle after reset deasserts.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state == IDLE) && !reset.
  - done = (state == DONE), taken from a register, never combinational.
- Accept condition: in_valid && in_ready, sampled at the rising edge that ends cycle 0.
  - bin_in is captured into a shift register.
  - The digit accumulator is cleared and the bit counter is loaded with IN_WIDTH.
- Range check at accept: if bin_in > 10^DIGITS - 1, go IDLE -> DONE.
  - Load every digit of bcd_out with 4'h9 and set overflow = 1.
  - done is high in cycle 1; in_ready returns high in cycle 2.
  - Evaluate the comparison in 64-bit arithmetic. If 10^DIGITS - 1 >= 2^IN_WIDTH - 1, overflow can never occur.
- Otherwise go IDLE -> SHIFT for exactly IN_WIDTH cycles (cycles 1..IN_WIDTH). Each cycle:
  - Every accumulator digit >= 5 has 3 added to it (4-bit add, no carry between digits).
  - Then {accumulator, shift register} shifts left by one, taking the binary MSB into digit 0 bit 0.
  - The counter decrements.
- When the counter reaches 1, go SHIFT -> DONE. The final shifted accumulator loads bcd_out and overflow is cleared.
- Cycle timing for the normal path:
  - done is high in cycle IN_WIDTH+1; with default IN_WIDTH this is cycle 33.
  - DONE -> IDLE unconditionally; in_ready is high in cycle IN_WIDTH+2.
- Throughput: one conversion per IN_WIDTH+2 cycles on the normal path, or per 2 cycles on overflow.
- Digit correctness: the range check guarantees the value fits in DIGITS digits, so no accumulator digit ever exceeds 9 and no shift-out from the top digit is lost.
- in_valid while busy (SHIFT or DONE):
  - It is ignored and does not queue.
  - bin_in changes during SHIFT have no effect, because the value was captured at accept.
- in_valid held high continuously: a new accept occurs in every IDLE cycle, giving back-to-back conversions.
- bcd_out and overflow change only on the transition into DONE, or on reset. The display sees no intermediate shift values.
- Reset mid-conversion:
  - The conversion is aborted with no done pulse.
  - bcd_out and overflow return to 0 and the state returns to IDLE.
- bin_in = 0 produces all-zero digits after the full IN_WIDTH shift cycles. There is no early-exit optimisation.

Test Plan:
- Reset, then bin_in=0 with in_valid for 1 cycle -> done in cycle 33, bcd_out=12'h000, overflow=0; in_ready stays low in cycles 1-33 and is high in cycle 34.
- bin_in=255 -> done in cycle 33, bcd_out=12'h255, overflow=0. Then bin_in=999 -> bcd_out=12'h999, overflow=0.
- bin_in=1000 -> done in cycle 1, bcd_out=12'h999, overflow=1. Then bin_in=32'hFFFFFFFF -> same result; then bin_in=7 -> bcd_out=12'h007, overflow=0.
- Accept 123, then pulse in_valid with 456 in cycles 5 and 33 -> exactly one done, bcd_out=12'h123. A value presented in cycle 34 is accepted and yields 12'h456.
- Convert 42, then accept 87 and assert reset in cycle 10 for 1 cycle -> no done pulse; bcd_out=0 and overflow=0 after reset; in_ready high the following cycle.
- Parameter sweep IN_WIDTH=16, DIGITS=5: inputs 65535 and 9 -> bcd_out=20'h65535 and 20'h00009, done in cycle 17, overflow never set. Random self-checking run of 1000 values against a reference model for the default parameters.
